pwm_ramp_ctrl: RTL and testbench
================================

Name: pwm_ramp_ctrl

Overview:
Configuration sequencer in front of the PWM core. It accepts a target duty/period command through a valid/ready handshake. It applies the new period at the next PWM period boundary, then ramps duty toward the target in fixed steps, one step every RATE_DIV boundaries. Outputs drive the PWM core's duty_new/period_new inputs, so changes are glitch-free and soft-started.

Parameters:
W, 8, width of duty/period/step fields (matches PWM core width)
RATE_DIV, 4, number of period_end pulses between duty steps (>=1)
RESET_PERIOD, 255, period_cfg value after reset

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-low reset
cmd_valid  in  1  command present
cmd_ready  out  1  controller can accept command
cmd_duty  in  W  target duty
cmd_period  in  W  target period
cmd_step  in  W  duty increment per step (0 treated as 1)
abort  in  1  stop ramp, freeze current duty
period_end  in  1  1-cycle pulse from PWM core at counter wrap
duty_cfg  out  W  duty to PWM core
period_cfg  out  W  period to PWM core
cfg_update  out  1  1-cycle pulse when duty_cfg/period_cfg changed this cycle
busy  out  1  command in progress
done  out  1  1-cycle pulse when target reached

Behaviour:
- Reset (rst=0, async): state IDLE, duty_cfg=0, period_cfg=RESET_PERIOD, cmd_ready=1, busy=0, done=0, cfg_update=0, rate counter=0.
- States: IDLE, WAIT_EDGE, RAMP, DONE. cmd_ready=1 only in IDLE; busy=1 in WAIT_EDGE and RAMP.
- IDLE: on cmd_valid&cmd_ready, latch three values, then go to WAIT_EDGE:
  - tgt_period=cmd_period
  - tgt_duty=min(cmd_duty,cmd_period) (clamp)
  - step=max(cmd_step,1)
- WAIT_EDGE: on period_end:
  - period_cfg<=tgt_period
  - duty_cfg takes one step toward tgt_duty (step rule below)
  - cfg_update=1 on the following cycle, counter<=0
  - If the new duty equals tgt_duty, go to DONE; else go to RAMP.
  - If duty_cfg already equals tgt_duty, only the period changes; go to DONE.
- RAMP: each period_end increments the counter. When the counter reaches RATE_DIV-1, the counter resets, duty_cfg steps, and cfg_update pulses. When duty_cfg equals tgt_duty after a step, go to DONE.
- Step rule: compute in W+1 bits; no wrap.
  - If |tgt_duty-duty_cfg|<=step, duty_cfg<=tgt_duty.
  - Else duty_cfg<=duty_cfg+step when ramping up, or duty_cfg-step when ramping down.
- DONE: done=1 for exactly one cycle, then IDLE (cmd_ready=1 the next cycle).
- Latency: outputs are registered; duty_cfg/period_cfg/cfg_update change the cycle after the qualifying period_end.
- cmd_valid while busy: not accepted, no effect; upstream holds the command.
- abort (WAIT_EDGE/RAMP): next state IDLE, duty_cfg/period_cfg frozen at current values, no done, no cfg_update. Abort beats a simultaneous period_end. Abort in IDLE/DONE is ignored.
- Reset mid-ramp: all outputs return to reset values immediately.

Test Plan:
- Reset: hold rst=0 with period_end toggling -> duty_cfg=0, period_cfg=255, cmd_ready=1, busy=0, no cfg_update.
- Ramp up (RATE_DIV=2): cmd duty=32, period=127, step=8 from duty 0 -> duty_cfg=8 and period_cfg=127 after 1st period_end; then 16, 24, 32 after the 3rd, 5th and 7th period_end; done pulses once; busy drops.
- Ramp down with saturation: from duty 96, cmd duty=32, period=127, step=20 -> sequence 76, 56, 36, 32; the last step saturates with no undershoot.
- Clamp + period change: cmd duty=200, period=63, step=255 from duty 32 -> at 1st period_end, period_cfg=63 and duty_cfg=63; done follows.
- Abort coincident with period_end mid-ramp -> duty_cfg unchanged, busy=0 next cycle, no done, cmd_ready=1.
- Handshake edges:
  - cmd_step=0 -> duty moves by 1 per step.
  - Second cmd_valid while busy -> cmd_ready=0, not latched; accepted only after done.

Source files
------------

// File: rtl/pwm_ramp_ctrl.sv
// Command sequencer for the PWM core: applies a new period at the next
// period boundary, then soft-steps duty toward the clamped target.
module pwm_ramp_ctrl #(
   parameter int W            = 8,
   parameter int RATE_DIV     = 4,
   parameter int RESET_PERIOD = 255
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         cmd_valid,
   output logic         cmd_ready,
   input  logic [W-1:0] cmd_duty,
   input  logic [W-1:0] cmd_period,
   input  logic [W-1:0] cmd_step,
   input  logic         abort,
   input  logic         period_end,
   output logic [W-1:0] duty_cfg,
   output logic [W-1:0] period_cfg,
   output logic         cfg_update,
   output logic         busy,
   output logic         done
);

   localparam int CW = (RATE_DIV > 1) ? $clog2(RATE_DIV) : 1;

   typedef enum logic [1:0] {
      S_IDLE,
      S_WAIT_EDGE,
      S_RAMP,
      S_DONE
   } state_t;

   state_t        r_state;
   state_t        w_next;
   logic [W-1:0]  r_tgt_duty;
   logic [W-1:0]  r_tgt_period;
   logic [W-1:0]  r_step;
   logic [W-1:0]  r_duty;
   logic [W-1:0]  r_period;
   logic          r_upd;
   logic [CW-1:0] r_cnt;

   logic          w_up;
   logic [W:0]    w_diff;
   logic [W-1:0]  w_stepped;
   logic [W-1:0]  w_step_duty;
   logic          w_cnt_wrap;
   logic          w_apply;
   logic          w_take;
   logic [W-1:0]  w_clamp;
   logic [W-1:0]  w_min_step;

   // Saturating step: never overshoots the target in either direction
   assign w_up        = (r_tgt_duty > r_duty);
   assign w_diff      = w_up ? ({1'b0, r_tgt_duty} - {1'b0, r_duty})
                             : ({1'b0, r_duty} - {1'b0, r_tgt_duty});
   assign w_stepped   = w_up ? (r_duty + r_step) : (r_duty - r_step);
   assign w_step_duty = (w_diff <= {1'b0, r_step}) ? r_tgt_duty : w_stepped;

   assign w_cnt_wrap  = (r_cnt == CW'(RATE_DIV - 1));
   assign w_take      = cmd_valid && (r_state == S_IDLE);
   assign w_clamp     = (cmd_duty > cmd_period) ? cmd_period : cmd_duty;
   assign w_min_step  = (cmd_step == '0) ? W'(1) : cmd_step;

   assign cmd_ready   = (r_state == S_IDLE);
   assign busy        = (r_state == S_WAIT_EDGE) || (r_state == S_RAMP);
   assign done        = (r_state == S_DONE);
   assign duty_cfg    = r_duty;
   assign period_cfg  = r_period;
   assign cfg_update  = r_upd;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) r_state <= S_IDLE;
      else      r_state <= w_next;
   end

   always_comb begin
      w_next  = r_state;
      w_apply = 1'b0;
      unique case (r_state)
         S_IDLE: begin
            if (cmd_valid) w_next = S_WAIT_EDGE;
         end
         S_WAIT_EDGE: begin
            if (abort) begin
               w_next = S_IDLE;
            end else if (period_end) begin
               w_apply = 1'b1;
               w_next  = (w_step_duty == r_tgt_duty) ? S_DONE : S_RAMP;
            end
         end
         S_RAMP: begin
            if (abort) begin
               w_next = S_IDLE;
            end else if (period_end && w_cnt_wrap) begin
               w_apply = 1'b1;
               w_next  = (w_step_duty == r_tgt_duty) ? S_DONE : S_RAMP;
            end
         end
         S_DONE: w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_tgt_duty   <= '0;
         r_tgt_period <= W'(RESET_PERIOD);
         r_step       <= W'(1);
         r_duty       <= '0;
         r_period     <= W'(RESET_PERIOD);
         r_upd        <= 1'b0;
         r_cnt        <= '0;
      end else begin
         r_upd <= w_apply;
         if (w_take) begin
            r_tgt_duty   <= w_clamp;
            r_tgt_period <= cmd_period;
            r_step       <= w_min_step;
         end
         if (w_apply) begin
            r_duty   <= w_step_duty;
            r_period <= r_tgt_period;
            r_cnt    <= '0;
         end else if (r_state == S_RAMP && period_end && !abort) begin
            r_cnt <= r_cnt + CW'(1);
         end
      end
   end

endmodule

// File: tb/tb_pwm_ramp_ctrl.sv
// Scoreboard bench for pwm_ramp_ctrl with RATE_DIV=2: expected config
// updates and done pulses are queued by the stimulus, popped by a monitor.
module tb_pwm_ramp_ctrl;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst;
   logic         cmd_valid;
   logic         cmd_ready;
   logic [W-1:0] cmd_duty;
   logic [W-1:0] cmd_period;
   logic [W-1:0] cmd_step;
   logic         abort;
   logic         period_end;
   logic [W-1:0] duty_cfg;
   logic [W-1:0] period_cfg;
   logic         cfg_update;
   logic         busy;
   logic         done;

   int n_chk  = 0;
   int n_pass = 0;

   logic [15:0] exp_cfg[$];
   logic [7:0]  exp_done[$];

   pwm_ramp_ctrl #(
      .W(W),
      .RATE_DIV(2),
      .RESET_PERIOD(255)
   ) dut (
      .clk(clk),
      .rst(rst),
      .cmd_valid(cmd_valid),
      .cmd_ready(cmd_ready),
      .cmd_duty(cmd_duty),
      .cmd_period(cmd_period),
      .cmd_step(cmd_step),
      .abort(abort),
      .period_end(period_end),
      .duty_cfg(duty_cfg),
      .period_cfg(period_cfg),
      .cfg_update(cfg_update),
      .busy(busy),
      .done(done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      n_chk++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", name, act, exp);
   endtask

   // Monitor: every cfg_update / done pulse must match the queue head
   always @(negedge clk) begin
      if (rst) begin
         if (cfg_update) begin
            if (exp_cfg.size() == 0) begin
               chk("unexpected_cfg_update", 1, 0);
            end else begin
               logic [15:0] e;
               e = exp_cfg.pop_front();
               chk("cfg_duty", int'(duty_cfg), int'(e[15:8]));
               chk("cfg_period", int'(period_cfg), int'(e[7:0]));
            end
         end
         if (done) begin
            if (exp_done.size() == 0) begin
               chk("unexpected_done", 1, 0);
            end else begin
               logic [7:0] d;
               d = exp_done.pop_front();
               chk("done_duty", int'(duty_cfg), int'(d));
            end
         end
      end
   end

   task automatic cyc(input logic pe);
      period_end = pe;
      @(posedge clk);
      #1;
      period_end = 1'b0;
   endtask

   // One period_end pulse followed by one quiet cycle
   task automatic pes(input int n);
      for (int i = 0; i < n; i++) begin
         cyc(1'b1);
         cyc(1'b0);
      end
   endtask

   task automatic push_cfg(input logic [7:0] d, input logic [7:0] p);
      exp_cfg.push_back({d, p});
   endtask

   task automatic send(input logic [7:0] d, input logic [7:0] p,
                       input logic [7:0] s);
      int waited;
      waited = 0;
      cmd_valid  = 1'b1;
      cmd_duty   = d;
      cmd_period = p;
      cmd_step   = s;
      while (!cmd_ready && waited < 20) begin
         cyc(1'b0);
         waited++;
      end
      if (!cmd_ready) chk("cmd_ready_timeout", 0, 1);
      cyc(1'b0);
      cmd_valid = 1'b0;
   endtask

   initial begin
      rst        = 1'b0;
      cmd_valid  = 1'b0;
      cmd_duty   = '0;
      cmd_period = '0;
      cmd_step   = '0;
      abort      = 1'b0;
      period_end = 1'b0;

      for (int i = 0; i < 4; i++) begin
         cyc(i[0]);
         chk("rst_duty", int'(duty_cfg), 0);
         chk("rst_period", int'(period_cfg), 255);
         chk("rst_ready", int'(cmd_ready), 1);
         chk("rst_busy", int'(busy), 0);
         chk("rst_update", int'(cfg_update), 0);
      end
      rst = 1'b1;
      cyc(1'b0);

      // Ramp up 0 -> 32, step 8
      push_cfg(8, 127);
      push_cfg(16, 127);
      push_cfg(24, 127);
      push_cfg(32, 127);
      exp_done.push_back(32);
      send(32, 127, 8);
      chk("up_busy", int'(busy), 1);
      chk("up_ready", int'(cmd_ready), 0);
      pes(7);
      cyc(1'b0);
      chk("up_busy_end", int'(busy), 0);
      chk("up_ready_end", int'(cmd_ready), 1);

      // Reach 96, then ramp down with saturating last step
      push_cfg(96, 127);
      exp_done.push_back(96);
      send(96, 127, 255);
      pes(1);
      cyc(1'b0);
      push_cfg(76, 127);
      push_cfg(56, 127);
      push_cfg(36, 127);
      push_cfg(32, 127);
      exp_done.push_back(32);
      send(32, 127, 20);
      pes(7);
      cyc(1'b0);
      chk("down_final", int'(duty_cfg), 32);

      // Clamp duty to period and change period
      push_cfg(63, 63);
      exp_done.push_back(63);
      send(200, 63, 255);
      pes(1);
      cyc(1'b0);

      // Abort coincident with a stepping period_end
      push_cfg(58, 100);
      send(10, 100, 5);
      pes(1);
      cyc(1'b1);
      abort = 1'b1;
      cyc(1'b1);
      abort = 1'b0;
      chk("abort_duty", int'(duty_cfg), 58);
      chk("abort_period", int'(period_cfg), 100);
      chk("abort_busy", int'(busy), 0);
      chk("abort_ready", int'(cmd_ready), 1);
      chk("abort_no_update", int'(cfg_update), 0);
      chk("abort_no_done", int'(done), 0);
      abort = 1'b1;
      cyc(1'b1);
      abort = 1'b0;
      chk("idle_abort_ready", int'(cmd_ready), 1);

      // Step 0 acts as 1; second command held while busy
      push_cfg(59, 100);
      push_cfg(60, 100);
      exp_done.push_back(60);
      send(60, 100, 0);
      cmd_valid  = 1'b1;
      cmd_duty   = 70;
      cmd_period = 100;
      cmd_step   = 3;
      chk("hold_ready0", int'(cmd_ready), 0);
      cyc(1'b1);
      chk("hold_ready1", int'(cmd_ready), 0);
      cyc(1'b0);
      cyc(1'b1);
      cyc(1'b0);
      cyc(1'b1);
      chk("hold_ready_done", int'(cmd_ready), 0);
      chk("step1_duty", int'(duty_cfg), 60);
      cyc(1'b0);
      chk("hold_ready_idle", int'(cmd_ready), 1);
      cyc(1'b0);
      cmd_valid = 1'b0;
      chk("second_busy", int'(busy), 1);
      push_cfg(63, 100);
      push_cfg(66, 100);
      push_cfg(69, 100);
      push_cfg(70, 100);
      exp_done.push_back(70);
      pes(7);
      cyc(1'b0);
      chk("second_final", int'(duty_cfg), 70);

      // Asynchronous reset mid-ramp
      push_cfg(60, 50);
      send(0, 50, 10);
      pes(1);
      #2;
      rst = 1'b0;
      #1;
      chk("mid_rst_duty", int'(duty_cfg), 0);
      chk("mid_rst_period", int'(period_cfg), 255);
      chk("mid_rst_busy", int'(busy), 0);
      chk("mid_rst_ready", int'(cmd_ready), 1);
      cyc(1'b0);
      rst = 1'b1;
      cyc(1'b0);
      cyc(1'b0);

      chk("cfg_queue_left", exp_cfg.size(), 0);
      chk("done_queue_left", exp_done.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
